// File: rtl/uart_cmd_sequencer_if.sv
// Byte-receiver input and sequence-generator control plane of uart_cmd_sequencer.
// The slave modport is the sequencer side; the master modport is the byte-source/observer side.
interface uart_cmd_sequencer_if;
    logic        flag;
    logic [7:0]  rx_1;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        run;
    logic        stop;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;
    logic [7:0]  frame_cnt;

    modport slave (
        input  flag, rx_1,
        output wr_en, wr_addr, wr_data, run, stop, err, err_code, busy, frame_cnt
    );

    modport master (
        output flag, rx_1,
        input  wr_en, wr_addr, wr_data, run, stop, err, err_code, busy, frame_cnt
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Parses 8-byte frames (SYNC CMD ADDR D3 D2 D1 D0 CHK) from the byte receiver and
// issues write/run/stop pulses, with checksum, unknown-command and inter-byte timeout errors.
//
// state  | meaning
// S_IDLE | waiting for sync_byte; other bytes dropped
// S_CMD  | expecting command byte
// S_ADDR | expecting address byte
// S_DATA | expecting data byte idx_q (0..3, MSB first)
// S_CHK  | expecting checksum byte; frame is checked and executed here
module uart_cmd_sequencer #(
    parameter int unsigned timeout_cyc = 32000,
    parameter logic [7:0]  sync_byte   = 8'hA5
) (
    input  logic                  c_rx,
    input  logic                  rst_n,
    uart_cmd_sequencer_if.slave   bus
);

    localparam int unsigned    GW       = (timeout_cyc > 2) ? $clog2(timeout_cyc) : 1;
    localparam logic [GW-1:0]  GAP_LAST = GW'(timeout_cyc - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CHK
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [7:0]     addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [7:0]     xor_q, xor_d;

    logic           wr_en_q, wr_en_d;
    logic [7:0]     wr_addr_q, wr_addr_d;
    logic [31:0]    wr_data_q, wr_data_d;
    logic           run_q, run_d;
    logic           stop_q, stop_d;
    logic           err_q, err_d;
    logic [1:0]     code_q, code_d;
    logic [7:0]     cnt_q, cnt_d;

    logic           cmd_known;
    logic           gap_expired;

    assign cmd_known   = (cmd_q == 8'h01) || (cmd_q == 8'h02) || (cmd_q == 8'h03);
    // An arriving byte always beats an expiring gap counter.
    assign gap_expired = (state_q != S_IDLE) && !bus.flag && (gap_q == GAP_LAST);

    always_ff @(posedge c_rx or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            xor_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            run_q     <= 1'b0;
            stop_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            xor_q     <= xor_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            run_q     <= run_d;
            stop_q    <= stop_d;
            err_q     <= err_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        xor_d     = xor_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        run_d     = 1'b0;
        stop_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        cnt_d     = cnt_q;

        if (state_q == S_IDLE || bus.flag) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q + GW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.flag && bus.rx_1 == sync_byte) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.flag) begin
                    cmd_d   = bus.rx_1;
                    xor_d   = bus.rx_1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.flag) begin
                    addr_d  = bus.rx_1;
                    xor_d   = xor_q ^ bus.rx_1;
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.flag) begin
                    data_d = {data_q[23:0], bus.rx_1};
                    xor_d  = xor_q ^ bus.rx_1;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (bus.flag) begin
                    state_d = S_IDLE;
                    if (bus.rx_1 != xor_q) begin
                        err_d  = 1'b1;
                        code_d = 2'd1;
                    end else if (!cmd_known) begin
                        err_d  = 1'b1;
                        code_d = 2'd3;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        case (cmd_q)
                            8'h01: begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = data_q;
                            end
                            8'h02:   run_d  = 1'b1;
                            default: stop_d = 1'b1;
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (gap_expired) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = 2'd2;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.run       = run_q;
    assign bus.stop      = stop_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed plus randomized frames checked against a frame-level reference model
// of the sequencer's outputs.
module tb_uart_cmd_sequencer;

    localparam int unsigned TO = 50;

    logic c_rx  = 1'b0;
    logic rst_n = 1'b0;

    uart_cmd_sequencer_if bus ();

    uart_cmd_sequencer #(.timeout_cyc(TO), .sync_byte(8'hA5)) dut (
        .c_rx  (c_rx),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 c_rx = ~c_rx;

    int tests = 0;
    int fails = 0;
    int n_wr = 0, n_run = 0, n_stop = 0, n_err = 0;

    // Reference state: what the outputs should be after the last completed frame/error.
    logic [7:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [7:0]  m_cnt  = '0;
    logic [1:0]  m_code = '0;
    logic        m_wr, m_run, m_stop, m_err;
    int          m_pulses = 0;

    always @(negedge c_rx) begin
        if (bus.wr_en === 1'b1) n_wr++;
        if (bus.run   === 1'b1) n_run++;
        if (bus.stop  === 1'b1) n_stop++;
        if (bus.err   === 1'b1) n_err++;
    end

    function automatic logic [7:0] fb(input logic [63:0] f, input int i);
        return f[63-8*i -: 8];
    endfunction

    function automatic logic [63:0] mk(input logic [7:0] cmd, input logic [7:0] addr,
                                       input logic [31:0] data, input logic bad);
        logic [7:0] c;
        c = cmd ^ addr ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
        if (bad) c = c ^ 8'($urandom_range(255, 1));
        return {8'hA5, cmd, addr, data, c};
    endfunction

    function automatic logic [63:0] mk_rand(input logic valid_only);
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic        bad;
        cmd  = 8'($urandom_range(3, 1));
        bad  = 1'b0;
        addr = ($urandom_range(7, 0) == 0) ? 8'hA5 : 8'($urandom);
        if (!valid_only) begin
            if ($urandom_range(9, 0) >= 7) cmd = 8'($urandom);
            bad = ($urandom_range(3, 0) == 0);
        end
        return mk(cmd, addr, $urandom, bad);
    endfunction

    task automatic model_frame(input logic [63:0] f);
        logic [7:0] x;
        logic [7:0] cmd;
        x = '0;
        for (int i = 1; i <= 6; i++) x ^= fb(f, i);
        cmd    = fb(f, 1);
        m_wr   = 1'b0;
        m_run  = 1'b0;
        m_stop = 1'b0;
        m_err  = 1'b0;
        if (x != fb(f, 7)) begin
            m_err  = 1'b1;
            m_code = 2'd1;
        end else if (cmd < 8'h01 || cmd > 8'h03) begin
            m_err  = 1'b1;
            m_code = 2'd3;
        end else begin
            m_cnt = m_cnt + 8'd1;
            if (cmd == 8'h01) begin
                m_wr   = 1'b1;
                m_addr = fb(f, 2);
                m_data = f[39:8];
            end else if (cmd == 8'h02) begin
                m_run = 1'b1;
            end else begin
                m_stop = 1'b1;
            end
        end
        m_pulses++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic busy_exp);
        chk("wr_en",     32'(bus.wr_en),     32'(m_wr));
        chk("run",       32'(bus.run),       32'(m_run));
        chk("stop",      32'(bus.stop),      32'(m_stop));
        chk("err",       32'(bus.err),       32'(m_err));
        chk("err_code",  32'(bus.err_code),  32'(m_code));
        chk("wr_addr",   32'(bus.wr_addr),   32'(m_addr));
        chk("wr_data",   bus.wr_data,        m_data);
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
        chk("busy",      32'(bus.busy),      32'(busy_exp));
    endtask

    task automatic drive(input logic f, input logic [7:0] b);
        @(negedge c_rx);
        bus.flag = f;
        bus.rx_1 = b;
    endtask

    // Optional idle gap of idle_n cycles inserted before byte gap_pos.
    task automatic send_frame(input logic [63:0] f, input int gap_pos, input int idle_n);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_pos) repeat (idle_n) drive(1'b0, 8'h00);
            drive(1'b1, fb(f, i));
            if (i == 1) chk("busy_mid", 32'(bus.busy), 32'd1);
        end
        drive(1'b0, 8'h00);
        model_frame(f);
        check_outputs(1'b0);
    endtask

    // Second SYNC lands in the cycle right after the first CHK.
    task automatic send_b2b(input logic [63:0] f1, input logic [63:0] f2);
        logic [127:0] s;
        s = {f1, f2};
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, s[127-8*i -: 8]);
            if (i == 8) begin
                model_frame(f1);
                check_outputs(1'b0);
            end
        end
        drive(1'b0, 8'h00);
        model_frame(f2);
        check_outputs(1'b0);
    endtask

    initial begin
        int k;
        int n;
        logic got;

        bus.flag = 1'b0;
        bus.rx_1 = 8'h00;
        m_wr = 1'b0; m_run = 1'b0; m_stop = 1'b0; m_err = 1'b0;

        repeat (3) @(negedge c_rx);
        rst_n = 1'b1;
        @(negedge c_rx);
        check_outputs(1'b0);

        send_frame(64'hA501101234567819, -1, 0);
        send_b2b(64'hA502000000000002, 64'hA503000000000003);
        send_frame(64'hA501101234567818, -1, 0);
        send_frame(64'hA507000000000007, -1, 0);

        // Noise in IDLE is dropped silently.
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hFF);
        drive(1'b0, 8'h00);
        repeat (2) @(negedge c_rx);
        chk("noise_busy",   32'(bus.busy), 32'd0);
        chk("noise_pulses", 32'(n_wr + n_run + n_stop + n_err), 32'(m_pulses));

        // Partial frame, then silence until timeout; k counts negedges after the last byte.
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h10);
        got = 1'b0;
        for (k = 1; k <= int'(TO) + 10; k++) begin
            drive(1'b0, 8'h00);
            if (bus.err === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("timeout_seen", 32'(got), 32'd1);
        chk("timeout_lat",  32'(k),   32'(TO + 1));
        m_wr = 1'b0; m_run = 1'b0; m_stop = 1'b0; m_err = 1'b1;
        m_code = 2'd2;
        m_pulses++;
        check_outputs(1'b0);

        send_frame(mk(8'h01, 8'h3C, 32'hCAFEF00D, 1'b0), -1, 0);
        // Byte arriving exactly as the gap counter reaches its last value is accepted.
        send_frame(mk(8'h01, 8'h44, 32'h0BADBEEF, 1'b0), 3, TO - 1);
        send_frame(mk(8'h02, 8'h00, 32'h0, 1'b0), 7, TO - 1);

        // Reset after four bytes of a frame.
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h77);
        drive(1'b1, 8'h99);
        @(negedge c_rx);
        bus.flag = 1'b0;
        rst_n = 1'b0;
        #1;
        m_addr = '0; m_data = '0; m_cnt = '0; m_code = '0;
        m_wr = 1'b0; m_run = 1'b0; m_stop = 1'b0; m_err = 1'b0;
        check_outputs(1'b0);
        @(negedge c_rx);
        rst_n = 1'b1;
        send_frame(64'hA501101234567819, -1, 0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(3, 0) == 0) send_b2b(mk_rand(1'b0), mk_rand(1'b0));
            else send_frame(mk_rand(1'b0), -1, 0);
        end

        n = 256 - int'(m_cnt);
        for (int i = 0; i < n; i++) send_frame(mk_rand(1'b1), -1, 0);
        chk("wrap", 32'(bus.frame_cnt), 32'd0);

        repeat (2) @(negedge c_rx);
        chk("pulse_total", 32'(n_wr + n_run + n_stop + n_err), 32'(m_pulses));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
